load_store_unit: RTL

- Memory stage between execute and the data RAM; executes lw/sw word accesses issued by execute (opcodes lw = 7'b0000011, sw = 7'b0100011).
- Checks alignment and range, runs a req/ack handshake with a variable-latency RAM and bounds it with a timeout.
- Returns load data plus a destination register to writeback; stalls upstream while an access is outstanding.

---
 rtl/types_pkg.sv | 19 +
 rtl/lsu_timeout_counter.sv | 27 ++
 rtl/load_store_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared widths, bus types and the load/store unit state encoding.
package types_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int ADDRESS_WIDTH       = 5;
  localparam int RAM_ADDRESS_WIDTH   = 18;
  localparam int RAM_WORD_ADDR_WIDTH = RAM_ADDRESS_WIDTH - 2;
  localparam int LSU_TIMEOUT         = 16;

  typedef logic [DATA_WIDTH-1:0]    DATA_BUS;
  typedef logic [ADDRESS_WIDTH-1:0] ADDR_BUS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_timeout_counter.sv
// Saturating 8-bit cycle counter; expired is combinational once the count reaches LIMIT-1.
// Clear has priority over enable; counting stops while expired is high.
module lsu_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt_q;

  assign expired = (cnt_q == 8'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Word lw/sw memory stage: alignment/range check, RAM req/ack with timeout, one-cycle result pulse.
// Faulted access completes one cycle after accept, RAM access one cycle after ack; in_ready only in IDLE.
module load_store_unit
  import types_pkg::*;
#(
  parameter int DATA_WIDTH        = types_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH     = types_pkg::ADDRESS_WIDTH,
  parameter int RAM_ADDRESS_WIDTH = types_pkg::RAM_ADDRESS_WIDTH,
  parameter int TIMEOUT_CYCLES    = types_pkg::LSU_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_is_load,
  input  logic                         in_is_store,
  input  logic [DATA_WIDTH-1:0]        in_addr,
  input  logic [DATA_WIDTH-1:0]        in_wdata,
  input  logic [ADDRESS_WIDTH-1:0]     in_rd,
  output logic                         ram_req,
  output logic                         ram_we,
  output logic [RAM_ADDRESS_WIDTH-3:0] ram_addr,
  output logic [DATA_WIDTH-1:0]        ram_wdata,
  input  logic [DATA_WIDTH-1:0]        ram_rdata,
  input  logic                         ram_ack,
  output logic                         out_valid,
  output logic                         out_wb,
  output logic [ADDRESS_WIDTH-1:0]     out_rd,
  output logic [DATA_WIDTH-1:0]        out_rdata,
  output logic                         out_err
);

  lsu_state_t state_q, state_d;

  logic                         is_load_q;
  logic [RAM_ADDRESS_WIDTH-3:0] addr_q;
  logic [DATA_WIDTH-1:0]        wdata_q;
  logic [ADDRESS_WIDTH-1:0]     rd_q;
  logic [DATA_WIDTH-1:0]        rdata_q;
  logic                         err_q;

  logic accept;
  logic fault;
  logic in_req;
  logic in_done;
  logic expired;

  assign in_req  = (state_q == REQ);
  assign in_done = (state_q == DONE);
  assign accept  = (state_q == IDLE) && in_valid;

  // Exactly one of load/store must be set; anything else is an illegal op.
  assign fault = (|in_addr[1:0])
               || (|in_addr[DATA_WIDTH-1:RAM_ADDRESS_WIDTH])
               || (in_is_load == in_is_store);

  lsu_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (in_req && !ram_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = fault ? DONE : REQ;
        end
      end
      REQ: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (ram_ack || expired) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      is_load_q <= in_is_load;
      addr_q    <= in_addr[RAM_ADDRESS_WIDTH-1:2];
      wdata_q   <= in_wdata;
      rd_q      <= in_rd;
      rdata_q   <= '0;
      err_q     <= fault;
    end else if (in_req) begin
      if (ram_ack) begin
        err_q <= 1'b0;
        if (is_load_q) begin
          rdata_q <= ram_rdata;
        end
      end else if (expired) begin
        err_q <= 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);

  assign ram_req   = in_req;
  assign ram_we    = in_req && !is_load_q;
  assign ram_addr  = in_req ? addr_q : '0;
  assign ram_wdata = in_req ? wdata_q : '0;

  assign out_valid = in_done;
  assign out_err   = in_done && err_q;
  assign out_wb    = in_done && is_load_q && !err_q;
  assign out_rd    = in_done ? rd_q : '0;
  assign out_rdata = (in_done && is_load_q && !err_q) ? rdata_q : '0;

endmodule
